// File: rtl/nes_loader_pkg.sv
// Shared types and constants for the NES ROM download path into SDRAM port A.
package nes_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } ld_state_t;

  localparam int          INES_HDR_LEN = 16;
  localparam logic [31:0] INES_MAGIC   = 32'h4E45531A;
  localparam int          PRG_UNIT     = 16384;
  localparam int          CHR_UNIT     = 8192;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } wr_req_t;

  // Byte i of "NES",0x1A in stream order.
  function automatic logic [7:0] magic_byte(input logic [1:0] i);
    return INES_MAGIC[8*(3-int'(i)) +: 8];
  endfunction

endpackage

// File: rtl/nes_loader_fifo.sv
// Small synchronous FIFO, first-word fall-through; push while full is accepted
// when a pop happens in the same cycle.
module nes_loader_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/nes_rom_loader.sv
// Download-to-SDRAM bridge: one port-A byte write per CPU slot, CPU held while loading.
// NES_LOADER_HEADER_STRIP_EN enables iNES header decode and the PRG/CHR address split.
module nes_rom_loader
  import nes_loader_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [24:0] PRG_BASE   = 25'h0000000,
  parameter logic [24:0] CHR_BASE   = 25'h0200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clkref,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [7:0]  dl_data,
  output logic [24:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic        done,
  output logic        overflow,
  output logic [7:0]  hdr_prg_16k,
  output logic [7:0]  hdr_chr_8k,
  output logic [7:0]  hdr_mapper,
  output logic        hdr_valid
);

  ld_state_t   state;
  logic        dl_active_d, clkref_d, pend;
  logic        rise, fall, slot_end, in_load, hdr_phase;
  logic        data_wr, pop, push, drain_done, load_enter;
  logic        fifo_full, fifo_empty;
  logic [24:0] data_idx, wr_addr;
  wr_req_t     wreq, head;

  assign rise       = dl_active & ~dl_active_d;
  assign fall       = ~dl_active & dl_active_d;
  assign slot_end   = clkref_d & ~clkref;
  assign in_load    = (state == ST_LOAD);
  assign data_wr    = in_load & dl_wr & ~hdr_phase;
  assign pop        = slot_end & ~fifo_empty;
  assign push       = data_wr & (~fifo_full | pop);
  // mem_we low with an empty FIFO means the last slot has fully elapsed
  assign drain_done = fifo_empty & ~mem_we;
  assign load_enter = (rise & (state == ST_IDLE || state == ST_DONE)) |
                      ((state == ST_DRAIN) & drain_done & (pend | rise));
  assign wreq       = '{addr: wr_addr, data: dl_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      pend     <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
    end else if (load_enter) begin
      state    <= ST_LOAD;
      pend     <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: if (fall) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (drain_done) begin
            state    <= ST_DONE;
            cpu_hold <= 1'b0;
            done     <= 1'b1;
          end else if (rise) begin
            pend <= 1'b1;
          end else if (fall) begin
            pend <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Dropped bytes still advance the index so later bytes keep their file position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dl_active_d <= 1'b0;
      clkref_d    <= 1'b0;
      data_idx    <= '0;
      overflow    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
    end else begin
      dl_active_d <= dl_active;
      clkref_d    <= clkref;
      if (load_enter) begin
        data_idx <= '0;
        overflow <= 1'b0;
      end else if (data_wr) begin
        data_idx <= data_idx + 25'd1;
        if (!push) overflow <= 1'b1;
      end
      if (slot_end) begin
        mem_we <= ~fifo_empty;
        if (!fifo_empty) begin
          mem_addr <= head.addr;
          mem_din  <= head.data;
        end
      end
    end
  end

`ifdef NES_LOADER_HEADER_STRIP_EN
  logic [4:0]  hdr_idx;
  logic        magic_ok;
  logic [24:0] prg_bytes;
  logic        in_chr;

  assign hdr_phase = (hdr_idx < 5'(INES_HDR_LEN));
  assign prg_bytes = 25'(hdr_prg_16k) * 25'(PRG_UNIT);
  // A bad magic leaves hdr_valid low, which keeps every byte in PRG space
  assign in_chr    = hdr_valid & (hdr_prg_16k != 8'd0) & (data_idx >= prg_bytes);
  assign wr_addr   = in_chr ? CHR_BASE + (data_idx - prg_bytes) : PRG_BASE + data_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_idx     <= '0;
      magic_ok    <= 1'b0;
      hdr_prg_16k <= '0;
      hdr_chr_8k  <= '0;
      hdr_mapper  <= '0;
      hdr_valid   <= 1'b0;
    end else if (load_enter) begin
      hdr_idx     <= '0;
      magic_ok    <= 1'b0;
      hdr_prg_16k <= '0;
      hdr_chr_8k  <= '0;
      hdr_mapper  <= '0;
      hdr_valid   <= 1'b0;
    end else if (in_load && dl_wr && hdr_phase) begin
      hdr_idx <= hdr_idx + 5'd1;
      case (hdr_idx[3:0])
        4'd0:             magic_ok <= (dl_data == magic_byte(2'd0));
        4'd1, 4'd2, 4'd3: magic_ok <= magic_ok & (dl_data == magic_byte(hdr_idx[1:0]));
        4'd4:             hdr_prg_16k <= dl_data;
        4'd5:             hdr_chr_8k  <= dl_data;
        4'd6:             hdr_mapper[3:0] <= dl_data[7:4];
        4'd7:             hdr_mapper[7:4] <= dl_data[7:4];
        4'd15:            hdr_valid <= magic_ok;
        default: ;
      endcase
    end
  end
`else
  assign hdr_phase   = 1'b0;
  assign wr_addr     = PRG_BASE + data_idx;
  assign hdr_prg_16k = '0;
  assign hdr_chr_8k  = '0;
  assign hdr_mapper  = '0;
  assign hdr_valid   = 1'b0;
`endif

  nes_loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(wr_req_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wreq),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: doc/nes_rom_loader.md
# nes_rom_loader

Upstream write source for the SDRAM controller's CPU port (port A) during ROM download. Accepts the byte stream from the MiST data-io download channel, optionally strips and decodes the 16-byte iNES header, and queues bytes in a small FIFO. It issues one SDRAM byte write per CPU (clkref-high) slot, holding every write stable for a full clkref period. `cpu_hold` freezes the NES core while the load is in progress.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: entries of {addr, data}; power of two, ≥2.
- `PRG_BASE`, 25'h0000000: byte address of the first PRG byte.
- `CHR_BASE`, 25'h0200000: byte address of the first CHR byte.

Ports:
- `clk`  in  1  SDRAM state-machine clock (up to 128 MHz), the same clock as the controller.
- `reset`  in  1  asynchronous, active-high.
- `clkref`  in  1  slot reference, synchronous to `clk`; high = CPU slot, low = PPU slot.
- `dl_active`  in  1  download in progress (level).
- `dl_wr`  in  1  one-`clk` strobe, byte valid on `dl_data`.
- `dl_data`  in  8  download byte.
- `mem_addr`  out  25  byte address to the controller's `addrA`.
- `mem_din`  out  8  byte to the controller's `dinA`.
- `mem_we`  out  1  write request to the controller's `weA`.
- `cpu_hold`  out  1  stall the CPU/PPU while loading.
- `done`  out  1  level; load finished.
- `overflow`  out  1  sticky; a byte was dropped.
- `hdr_prg_16k`, `hdr_chr_8k`, `hdr_mapper`  out  8 each  decoded iNES fields.
- `hdr_valid`  out  1  magic "NES",0x1A matched.

## Operation
- FSM states and transitions:
  - IDLE → LOAD on a `dl_active` rising edge.
  - LOAD → DRAIN on a `dl_active` falling edge.
  - DRAIN → DONE when the FIFO is empty and the current slot's write is finished.
  - DONE → LOAD on a `dl_active` rising edge.
- A `dl_active` rise during DRAIN sets a pending bit. When drain completes, the FSM goes directly to LOAD instead of DONE.
- Entering LOAD clears the byte counter, `done`, `overflow`, `hdr_valid` and the header fields.
- `cpu_hold` = state is LOAD or DRAIN. `done` = state is DONE.
- Push rules:
  - In LOAD, `dl_wr` with the FIFO not full pushes {computed addr, `dl_data`}.
  - `dl_wr` with the FIFO full drops the byte and sets `overflow`.
  - `dl_wr` outside LOAD is ignored.
- Address computation (header strip on), with n = data-byte index after the header:
  - If `hdr_prg_16k`==0, or n < `hdr_prg_16k`×16384: addr = `PRG_BASE`+n.
  - Otherwise: addr = `CHR_BASE`+(n − `hdr_prg_16k`×16384).
  - Arithmetic is 25-bit and wraps modulo 2^25.
- Header bytes (indices 0–15) are never pushed:
  - Bytes 0–3 are compared against the magic.
  - Byte 4 → `hdr_prg_16k`; byte 5 → `hdr_chr_8k`.
  - `hdr_mapper` = {byte7[7:4], byte6[7:4]}.
  - `hdr_valid` is set after byte 15 only if the magic matched.
  - On a mismatch, the header bytes are still discarded and all remaining bytes are treated as PRG.
- Slot boundary = the `clk` cycle in which `clkref_d & ~clkref` (falling edge; `clkref_d` is `clkref` registered).
- At each slot boundary:
  - FIFO non-empty: pop, drive `mem_addr`/`mem_din`, and set `mem_we`=1.
  - FIFO empty: `mem_we`=0.
- Outputs change only at slot boundaries, so port A is stable for the whole following CPU slot.

## Timing
- Reset values:
  - `mem_we`, `cpu_hold`, `done`, `overflow`, `hdr_valid` = 0.
  - `mem_addr`, `mem_din`, and all `hdr_*` fields = 0.
  - State = IDLE, FIFO empty.
- Reset asserted mid-write drops `mem_we` immediately (asynchronous reset).
- Push-to-write latency: the byte appears on `mem_*` at the first slot boundary at least 1 `clk` after the push.
- Sustained rate: 1 byte per clkref period.
- A push and a pop in the same cycle are both allowed; when the FIFO is full, a same-cycle pop makes room and the push is accepted.
- `mem_we` stays high for exactly one clkref period per popped byte. The last write's slot completes before DONE.

## Configuration
- `NES_LOADER_HEADER_STRIP_EN` defined: header parsing and PRG/CHR split as described above.
- Not defined:
  - Every byte is pushed, with addr = `PRG_BASE`+byte index.
  - `hdr_*` outputs and `hdr_valid` are tied to 0.
  - The header registers are not synthesised.

## Structure
- `nes_loader_pkg` contains:
  - FSM state enum.
  - `INES_HDR_LEN`=16.
  - `INES_MAGIC`=32'h4E45531A.
  - `PRG_UNIT`=16384 and `CHR_UNIT`=8192.
- Sub-module `nes_loader_fifo`: synchronous FIFO of 33-bit entries, parameterised depth, with full/empty flags and simultaneous push/pop.

## Test plan
- Header off; load bytes 0xA5, 0x5A, then drop `dl_active` → `mem_we` pulses at addr 0 then 1 with data A5, 5A, each held one clkref period; `done`=1, `cpu_hold`=0.
- Header on; header "NES",0x1A,0x02,0x01,0x10,0x00 then 32768+8192 bytes → `hdr_valid`=1, `hdr_mapper`=0x01, `hdr_chr_8k`=1. PRG byte 32767 → addr 0x7FFF; first CHR byte → 0x200000.
- Header with bad magic → `hdr_valid`=0; the 16 header bytes are not written; byte 16 → addr 0.
- 6 `dl_wr` strobes on consecutive clks with `FIFO_DEPTH`=4 → `overflow`=1, and exactly 4 writes are issued.
- `reset` asserted during an active write → `mem_we`=0 in the same cycle, all outputs at reset values, state IDLE.
- `dl_active` re-rises during DRAIN → the FIFO drains, the FSM enters LOAD without asserting `done`, the counter restarts at `PRG_BASE`.
